rr_mux_arb: RTL
===============

# rr_mux_arb

Parametrised, registered N-channel selector with valid/ready handshakes on every input and on the output. It generalises the fixed 5-way 8-bit combinational mux to W-bit data and N channels. It offers three selection modes: direct select, fixed priority and round-robin. It sits between multiple producers and a single consumer, and provides one registered output stage so the consumer sees a clean one-cycle-latency stream.

## Interface
Parameters:
- N, default 5: number of input channels, range 2..16.
- W, default 8: data width in bits.
- SELW, default $clog2(N): width of the sel and out_sel fields. Derived; do not override.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  selection mode: 00 DIRECT, 01 FIXED, 10 RR, 11 reserved.
- sel  input  SELW  channel index used only in DIRECT mode.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  packed data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready (combinational); at most one bit set.
- out_valid  output  1  registered output valid.
- out_data  output  W  registered output data.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

## Operation
- The output register is loaded when load = !out_valid || out_ready. This means the stage accepts when it is empty or is being drained in the same cycle.
- The grant is computed combinationally each cycle from mode, sel, in_valid and ptr:
  - DIRECT: grant to channel sel if sel < N and in_valid[sel]. If sel >= N, there is no grant; this replaces the old all-zero default output.
  - FIXED: grant to the lowest-index channel with in_valid set.
  - RR: grant to the first channel with in_valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - 11: never grants; all in_ready bits are 0.
- in_ready[i] = !reset && load && grant_valid && (grant == i). Channels without a grant are never acknowledged.
- Accept occurs when in_valid[g] && in_ready[g]. On accept:
  - out_data <= in_data[g*W +: W], out_sel <= g, out_valid <= 1.
- Load cycle with no grant: out_valid <= 0. out_data and out_sel hold their previous values, and their contents are don't-care while out_valid = 0.
- Not a load cycle (out_valid = 1 and out_ready = 0): all output registers hold.
- ptr has width SELW and reset value 0.
  - In RR mode, each accept sets ptr <= (g == N-1) ? 0 : g+1.
  - In other modes ptr holds. Switching back to RR resumes from the held ptr.
- mode and sel may change on any cycle; they take effect on the same cycle's grant.
- Inputs are not required to hold in_valid until acknowledged. A producer drops data only under its own protocol; this block records nothing for channels that were not granted.

## Timing
- Reset (reset high at a rising edge): out_valid = 0, out_data = 0, out_sel = 0, ptr = 0. in_ready = 0 for as long as reset is high.
- Reset mid-transfer: any pending output word is discarded; no accept occurs during a reset cycle.
- Latency: data accepted at edge k appears on out_data with out_valid = 1 after edge k, i.e. one cycle.
- Throughput: one word per cycle while out_ready = 1 and a grant exists.
- Backpressure: while out_valid = 1 and out_ready = 0, all in_ready bits are 0 and out_data, out_sel and out_valid are stable.
- Simultaneous drain and fill: when out_ready = 1 and a grant exists in the same cycle, the old word leaves and the new word loads at the same edge, with no bubble.
- RR wrap-around: after a grant to channel N-1, ptr = 0.

## Test plan
- Reset: hold reset for 2 cycles with in_valid = 5'b11111 and out_ready = 1 -> in_ready = 0 throughout; after the reset edge out_valid = 0, out_data = 8'h00, out_sel = 0.
- DIRECT: mode = 00, sel = 3, in_data ch3 = 8'hA5, in_valid = 5'b11111, out_ready = 1 -> in_ready = 5'b01000; next cycle out_data = 8'hA5, out_sel = 3. Then set sel = 5 -> in_ready = 0 and out_valid = 0 on the following cycle.
- FIXED: mode = 01, in_valid = 5'b11110, chX data = 8'h10+X -> every cycle in_ready = 5'b00010 and out_data = 8'h11. Drop bit 1 -> the grant moves to channel 2 (8'h12).
- RR fairness and wrap: mode = 10, in_valid = 5'b11111, out_ready = 1 for 7 cycles -> out_sel sequence is 0, 1, 2, 3, 4, 0, 1.
- RR sparse: mode = 10, ptr = 2 (reached after granting ch1), in_valid = 5'b10010 -> grant ch4, then ch1, then ch4.
- Backpressure: out_valid = 1 with out_data = 8'h33, hold out_ready = 0 for 3 cycles -> in_ready = 0 and out_data = 8'h33 stable. Raise out_ready with ch2 valid (8'h44) -> in_ready[2] = 1 in that cycle and out_data = 8'h44 on the next edge.

Source files
------------

// File: rtl/rr_mux_arb.sv
// ---------------------------------------------------------------------------
// rr_mux_arb
//
// Registered N-channel selector with valid/ready handshakes on every input
// and on the output. One of N producers is chosen each cycle by direct
// select, fixed priority or round-robin. The chosen word is captured in a
// single output register, so the consumer sees a one-cycle-latency stream.
//
// Parameters
//   N     number of input channels (2..16)
//   W     data width in bits
//   SELW  width of sel / out_sel, derived from N (do not override)
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   mode       00 direct, 01 fixed priority, 10 round-robin, 11 reserved
//   sel        channel index used in direct mode
//   in_valid   per-channel valid, bit i is channel i
//   in_data    packed channel data, channel i at [i*W +: W]
//   in_ready   per-channel ready, combinational, at most one bit set
//   out_valid  registered output valid
//   out_data   registered output data
//   out_sel    index of the channel that supplied out_data
//   out_ready  consumer ready
// ---------------------------------------------------------------------------
module rr_mux_arb #(
  parameter int N    = 5,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_RR     = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  mode_e           mode_s;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            load;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic            accept;
  logic [W-1:0]    grant_data;

  assign mode_s = mode_e'(mode);

  // The output stage may take a new word when it is empty or when the
  // consumer is draining the current word on this same edge.
  assign load = !out_valid_q || out_ready;

  // Grant selection. Each mode only decides which channel, if any, would
  // be served; whether it is actually acknowledged depends on load and
  // reset further down.
  always_comb begin : grant_logic
    grant_valid = 1'b0;
    grant       = '0;
    unique case (mode_s)
      MODE_DIRECT: begin
        // An out-of-range sel simply matches no channel, so nothing is
        // granted instead of producing a default word.
        for (int i = 0; i < N; i++) begin
          if (sel == SELW'(i) && in_valid[i]) begin
            grant_valid = 1'b1;
            grant       = SELW'(i);
          end
        end
      end
      MODE_FIXED: begin
        for (int i = 0; i < N; i++) begin
          if (!grant_valid && in_valid[i]) begin
            grant_valid = 1'b1;
            grant       = SELW'(i);
          end
        end
      end
      MODE_RR: begin
        // Circular search split into two linear passes: first from ptr up
        // to N-1, then wrap around from 0. The second pass can revisit
        // channels at or above ptr, but those were already found idle.
        for (int i = 0; i < N; i++) begin
          if (!grant_valid && SELW'(i) >= ptr_q && in_valid[i]) begin
            grant_valid = 1'b1;
            grant       = SELW'(i);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (!grant_valid && in_valid[i]) begin
            grant_valid = 1'b1;
            grant       = SELW'(i);
          end
        end
      end
      default: begin
        grant_valid = 1'b0;
        grant       = '0;
      end
    endcase
  end

  // Acknowledge only the granted channel, and only when the output stage
  // can take the word and reset is not active.
  always_comb begin : ready_logic
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !reset && load && grant_valid && (grant == SELW'(i));
    end
  end

  assign accept = |(in_ready & in_valid);

  // Pick the granted channel's word out of the packed input bus.
  always_comb begin : data_mux
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // Next-state for the output register and round-robin pointer. On a load
  // cycle without a grant the stage empties but keeps the stale data and
  // index; under backpressure everything holds.
  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = grant_data;
        out_sel_d  = grant;
        if (mode_s == MODE_RR) begin
          ptr_d = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset; a reset edge discards any
  // pending output word and restarts round-robin at channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
